// File: rtl/cache_arbiter.sv
// cache_arbiter
// ----------------------------------------------------------------------------
// Shares the single physical-memory port between the I-cache and D-cache miss
// paths. One requester is granted at a time; its address, operation and write
// data are captured at grant and held for the whole memory transaction. The
// memory response is steered back only to the granted side. A recovery cycle
// follows every response so that a strobe still held across its response
// pulse is never serviced a second time.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : contention in IDLE is granted to the side that did not win
//               the previous grant (last_grant, resets to INST).
//   undefined : fixed priority, the D-cache always wins contention.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   i_read, i_addr         I-cache line read request (held until i_resp)
//   i_resp, i_rdata        I-cache completion pulse and read data
//   d_read, d_write        D-cache read / writeback request (held until d_resp)
//   d_addr, d_wdata        D-cache line address and writeback data
//   d_resp, d_rdata        D-cache completion pulse and read data
//   mem_read, mem_write    memory strobes, held until mem_resp
//   mem_addr, mem_wdata    latched address and write data
//   mem_resp, mem_rdata    memory completion pulse and read data
// ----------------------------------------------------------------------------
module cache_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_resp,
   output logic [LINE_WIDTH-1:0] i_rdata,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic                  d_resp,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic                  mem_resp,
   input  logic [LINE_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [LINE_WIDTH-1:0] wdata_reg, wdata_next;
   logic                  write_reg, write_next;

   logic d_req;
   logic grant_d;
   logic grant_i;
   logic serving;

`ifdef ARB_ROUND_ROBIN_EN
   typedef enum logic {INST, DATA} side_t;
   side_t last_grant_reg, last_grant_next;
`endif

   assign d_req = d_read | d_write;

   // Grant decision, only consulted while IDLE.
   always_comb begin
      grant_d = d_req;
`ifdef ARB_ROUND_ROBIN_EN
      // On contention, hand the port to the side that lost last time.
      if (d_req && i_read)
         grant_d = (last_grant_reg == INST);
`endif
   end

   assign grant_i = i_read & ~grant_d;

   // Next-state and capture logic.
   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      write_next = write_reg;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_next = last_grant_reg;
`endif
      unique case (state_reg)
         IDLE: begin
            if (grant_d) begin
               state_next = SERVE_D;
               addr_next  = d_addr;
               wdata_next = d_wdata;
               // A writeback wins when both D strobes are raised together.
               write_next = d_write;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_next = DATA;
`endif
            end else if (grant_i) begin
               state_next = SERVE_I;
               addr_next  = i_addr;
               write_next = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_next = INST;
`endif
            end
         end
         SERVE_I, SERVE_D: begin
            if (mem_resp)
               state_next = RECOVER;
         end
         RECOVER: begin
            // Requests are deliberately not sampled here: a strobe still
            // high in this cycle belongs to the transaction just completed.
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         wdata_reg <= '0;
         write_reg <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_reg <= INST;
`endif
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         write_reg <= write_next;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_reg <= last_grant_next;
`endif
      end
   end

   assign serving   = (state_reg == SERVE_I) || (state_reg == SERVE_D);
   assign mem_read  = serving & ~write_reg;
   assign mem_write = serving & write_reg;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;

   // A response arriving while reset is asserted belongs to an abandoned
   // transaction and is not forwarded.
   assign i_resp  = (state_reg == SERVE_I) & mem_resp & ~rst;
   assign d_resp  = (state_reg == SERVE_D) & mem_resp & ~rst;
   assign i_rdata = i_resp ? mem_rdata : '0;
   assign d_rdata = d_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
// Randomized bench for cache_arbiter. Two requester models and a memory model
// drive the DUT; a transaction-level reference (one service in flight, one
// blackout cycle after each response, grant rule from the arbitration policy)
// predicts every output each cycle. Honours ARB_ROUND_ROBIN_EN like the DUT.
module tb_cache_arbiter;
   localparam int AW   = 32;
   localparam int LW   = 256;
   localparam int NCYC = 4000;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_read;
   logic [AW-1:0] i_addr;
   logic          i_resp;
   logic [LW-1:0] i_rdata;
   logic          d_read, d_write;
   logic [AW-1:0] d_addr;
   logic [LW-1:0] d_wdata;
   logic          d_resp;
   logic [LW-1:0] d_rdata;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata;
   logic          mem_resp;
   logic [LW-1:0] mem_rdata;

   always #5 clk = ~clk;

   cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_resp(d_resp), .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int k = 0; k < LW/32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference model: the one transaction currently owning the memory port.
   bit            busy_m, who_d_m, wr_m, last_d_m, take_d, granted_d;
   int            cool_m, lat_m;
   logic [AW-1:0] addr_m;
   logic [LW-1:0] wdata_m;
   bit            e_ir, e_dr, resp_m;

   // Requester models.
   bit            i_pend, d_pend;
   int            i_tail, d_tail;
   logic [1:0]    d_op;
   logic [AW-1:0] i_addr_v, d_addr_v;
   logic [LW-1:0] d_wdata_v;
   int            n_i, n_d;

   initial begin
      rst = 1'b1; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
      d_addr = '0; d_wdata = '0; mem_resp = 1'b1; mem_rdata = rand_line();
      busy_m = 0; who_d_m = 0; wr_m = 0; last_d_m = 0; cool_m = 0; lat_m = 0;
      addr_m = '0; wdata_m = '0; i_pend = 0; d_pend = 0; i_tail = 0; d_tail = 0;
      d_op = 2'b01; i_addr_v = '0; d_addr_v = '0; d_wdata_v = '0; n_i = 0; n_d = 0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_mem_read",  mem_read,  0);
      check_eq("rst_mem_write", mem_write, 0);
      check_eq("rst_i_resp",    i_resp,    0);
      check_eq("rst_d_resp",    d_resp,    0);
      check_eq("rst_mem_addr",  mem_addr,  0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      check_eq("rst_i_rdata",   i_rdata,   0);
      check_eq("rst_d_rdata",   d_rdata,   0);

      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         cyc = c;
         // Drive this cycle's inputs.
         rst       = (c > 20) && ($urandom_range(0, 249) == 0);
         mem_rdata = rand_line();
         if (busy_m) mem_resp = !rst && (lat_m == 0);
         else        mem_resp = !rst && ($urandom_range(0, 7) == 0);
         i_read  = i_pend || (i_tail > 0);
         i_addr  = i_addr_v;
         d_read  = (d_pend || (d_tail > 0)) && d_op[0];
         d_write = (d_pend || (d_tail > 0)) && d_op[1];
         d_addr  = d_addr_v;
         d_wdata = d_wdata_v;

         @(negedge clk);
         resp_m = busy_m && mem_resp && !rst;
         e_ir   = resp_m && !who_d_m;
         e_dr   = resp_m && who_d_m;
         check_eq("mem_read",  mem_read,  busy_m && !wr_m);
         check_eq("mem_write", mem_write, busy_m && wr_m);
         check_eq("i_resp",    i_resp,    e_ir);
         check_eq("d_resp",    d_resp,    e_dr);
         check_eq("i_rdata",   i_rdata,   e_ir ? mem_rdata : '0);
         check_eq("d_rdata",   d_rdata,   e_dr ? mem_rdata : '0);
         if (busy_m) check_eq("mem_addr", mem_addr, addr_m);
         if (busy_m && wr_m) check_eq("mem_wdata", mem_wdata, wdata_m);
         if (e_ir) n_i++;
         if (e_dr) n_d++;

         // Advance model across the coming rising edge.
         if (rst) begin
            busy_m = 0; cool_m = 0; last_d_m = 0;
            i_pend = 0; i_tail = 0; d_pend = 0; d_tail = 0;
            addr_m = '0; wdata_m = '0; wr_m = 0;
         end else begin
            granted_d = 0;
            if (busy_m) begin
               if (resp_m) begin busy_m = 0; cool_m = 1; end
               else lat_m = lat_m - 1;
            end else if (cool_m > 0) begin
               cool_m = cool_m - 1;
            end else if (d_read || d_write || i_read) begin
               take_d = d_read || d_write;
`ifdef ARB_ROUND_ROBIN_EN
               if ((d_read || d_write) && i_read) take_d = !last_d_m;
               last_d_m = take_d;
`endif
               busy_m = 1; who_d_m = take_d; lat_m = $urandom_range(0, 3);
               if (take_d) begin
                  wr_m = d_write; addr_m = d_addr; wdata_m = d_wdata; granted_d = 1;
               end else begin
                  wr_m = 0; addr_m = i_addr;
               end
            end
            // I-cache: hold until resp, sometimes linger one cycle into recovery.
            if (e_ir) begin i_pend = 0; i_tail = $urandom_range(0, 1); end
            else if (i_tail > 0) i_tail = i_tail - 1;
            else if (!i_pend && $urandom_range(0, 2) == 0) begin
               i_pend = 1; i_addr_v = $urandom & ~32'h1f;
            end
            // D-cache: occasionally change inputs and drop right after grant.
            if (e_dr) begin d_pend = 0; d_tail = $urandom_range(0, 1); end
            else if (granted_d && $urandom_range(0, 2) == 0) begin
               d_pend = 0; d_addr_v = $urandom & ~32'h1f; d_wdata_v = rand_line();
            end else if (d_tail > 0) d_tail = d_tail - 1;
            else if (!d_pend && $urandom_range(0, 2) == 0) begin
               d_pend = 1; d_op = 2'($urandom_range(1, 3));
               d_addr_v = $urandom & ~32'h1f; d_wdata_v = rand_line();
            end
         end
      end

      cyc = NCYC;
      check_eq("i_served", (n_i > 0), 1);
      check_eq("d_served", (n_d > 0), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single physical-memory port between the instruction-cache and data-cache miss paths of the pipelined CPU. Each cache issues line-sized read or write requests with level-held strobes and waits for a one-cycle response. The arbiter grants one requester at a time and latches that request's address, operation and write data at grant. It forwards the transaction to memory and returns the response only to the granted side. A mandatory recovery cycle after every response guarantees a held strobe is never serviced twice.

## Interface
- ADDR_WIDTH, 32, byte address width of all three ports
- LINE_WIDTH, 256, cache-line data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_addr  in  ADDR_WIDTH  I-cache line address
- i_resp  out  1  one-cycle completion pulse to I-cache
- i_rdata  out  LINE_WIDTH  read data to I-cache, valid only while i_resp=1
- d_read, d_write  in  1 each  D-cache line read / writeback request, held until d_resp
- d_addr  in  ADDR_WIDTH  D-cache line address
- d_wdata  in  LINE_WIDTH  writeback data
- d_resp  out  1  one-cycle completion pulse to D-cache
- d_rdata  out  LINE_WIDTH  read data to D-cache, valid only while d_resp=1
- mem_read, mem_write  out  1 each  memory strobes, held until mem_resp
- mem_addr  out  ADDR_WIDTH  latched address
- mem_wdata  out  LINE_WIDTH  latched write data
- mem_resp  in  1  memory completion pulse
- mem_rdata  in  LINE_WIDTH  memory read data, valid with mem_resp

## Operation
- States: IDLE, SERVE_I, SERVE_D, RECOVER. Reset state is IDLE.
- IDLE:
  - If d_read|d_write, go to SERVE_D. Latch d_addr, d_wdata and op: write if d_write, else read. d_write wins if both strobes are set.
  - Otherwise, if i_read, go to SERVE_I. Latch i_addr and op=read.
  - Otherwise, stay in IDLE.
- SERVE_x:
  - mem_read/mem_write are decoded from the latched op.
  - mem_addr and mem_wdata are driven from the latch registers.
  - Latched values stay constant for the whole service, even if the requester changes or drops its inputs.
  - On mem_resp, pulse x_resp the same cycle and pass mem_rdata to x_rdata combinationally, then go to RECOVER.
- RECOVER: one cycle with all strobes and resps low, then go to IDLE.
- A requester that drops its strobe mid-service still receives its x_resp pulse.
- mem_resp while in IDLE or RECOVER is ignored. It produces no resp and no state change.
- i_rdata and d_rdata are 0 whenever their resp is low.
- Reset values: mem_read=0, mem_write=0, i_resp=0, d_resp=0, mem_addr=0, mem_wdata=0, i_rdata=0, d_rdata=0.
  - Latch registers clear to 0.
  - last_grant (used only when ARB_ROUND_ROBIN_EN is defined) resets to INST.
- rst asserted mid-service: next state is IDLE, and strobes are low from the following cycle. The memory transaction is abandoned, and no resp is issued for it.

## Timing
- Request sampled in IDLE at edge k: memory strobe asserted in cycle k+1, which is a 1-cycle grant latency.
- mem_resp in cycle n: x_resp is in the same cycle n, RECOVER is cycle n+1, IDLE is cycle n+2.
  - A pending request is sampled at the end of cycle n+2, with its strobe in cycle n+3.
- Minimum service period is 3 cycles when mem_resp arrives in the first strobe cycle.
- A requester held high across its resp pulse is not re-granted during RECOVER. It must deassert in cycle n+1 to avoid a repeat transaction.
- At most one of mem_read/mem_write is high in any cycle. i_resp and d_resp are never high together.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - When i_read and a D request coincide in IDLE, grant the side not in last_grant.
  - last_grant updates at every grant.
  - Uncontended requests are granted immediately regardless of last_grant.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: D always wins contention, and I may starve under continuous D traffic.
  - last_grant is not implemented.

## Test plan
- Solo I read: i_read=1, i_addr=0x00000060; memory responds 2 cycles after strobe with rdata=0xA5…A5. Expected: mem_read in cycle 1; i_resp for 1 cycle with i_rdata=0xA5…A5; d_resp stays 0.
- Simultaneous i_read (addr 0x100) and d_write (addr 0x200, wdata=0x1234…):
  - Macro undefined: D is served first and I second.
  - Macro defined: D first (last_grant=INST after reset), then a repeated collision grants I.
- Latch check: d_read to 0x40 granted, then the D-cache changes d_addr to 0x80 and drops d_read in the next cycle. Expected: mem_addr stays 0x40 until mem_resp, and d_resp still pulses.
- Held strobe: i_read kept high through i_resp and RECOVER. Expected: exactly one mem_read transaction by the end of RECOVER, and a second grant only from IDLE.
- Reset mid-service: rst asserted for one cycle while SERVE_D is waiting on mem. Expected: strobes are 0 next cycle, no d_resp, and a stray mem_resp afterwards is ignored.
- Both d_read and d_write high: expected mem_write=1, mem_read=0.
